// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8-bit asynchronous serial receiver with optional even/odd
//                parity, 16x oversampled mid-bit sampling, frame/parity
//                error flags and break (line-held-low) handling.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       sample_en_i,
    input  logic [2:0] Ctrl,
    input  logic       uart_rx_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       uart_busy_o
);

    localparam logic [3:0] TICK_MID = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] TICK_END = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       par_en_q, par_en_d;
    logic       par_odd_q, par_odd_d;
    logic       perr_q, perr_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       perr_out_q, perr_out_d;
    logic       ferr_q, ferr_d;
    logic       busy_q, busy_d;
    logic       sync1_q, sync2_q;
    logic       rx_s;

    assign rx_s = sync2_q;

    // Two-flop synchronizer for the asynchronous serial line; idles high
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_rx_i;
            sync2_q <= sync1_q;
        end
    end

    // State, counters, shift register and output registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            tick_q     <= 4'd0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            perr_q     <= 1'b0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            perr_q     <= perr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic: every sample is taken a whole bit period after the
    // previous one, starting from the middle of the start bit
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        perr_d     = perr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perr_out_d = perr_out_q;
        ferr_d     = ferr_q;

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    tick_d    = 4'd0;
                    par_en_d  = (Ctrl == 3'b001) || (Ctrl == 3'b011);
                    par_odd_d = (Ctrl == 3'b011);
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (sample_en_i) begin
                    if (tick_q == TICK_MID) begin
                        if (rx_s) begin
                            // Line went back high before mid-bit: a glitch
                            state_d = S_IDLE;
                        end else begin
                            tick_d  = 4'd0;
                            bit_d   = 3'd0;
                            state_d = S_DATA;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (sample_en_i) begin
                    if (tick_q == TICK_END) begin
                        tick_d  = 4'd0;
                        shift_d = {rx_s, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = par_en_q ? S_PARITY : S_STOP;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (sample_en_i) begin
                    if (tick_q == TICK_END) begin
                        tick_d  = 4'd0;
                        perr_d  = par_odd_q ? ~((^shift_q) ^ rx_s) : ((^shift_q) ^ rx_s);
                        state_d = S_STOP;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            S_STOP: begin
                if (sample_en_i) begin
                    if (tick_q == TICK_END) begin
                        tick_d     = 4'd0;
                        data_d     = shift_q;
                        valid_d    = 1'b1;
                        perr_out_d = par_en_q & perr_q;
                        ferr_d     = ~rx_s;
                        state_d    = rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            S_BREAK: begin
                // Swallow a held-low line until it returns to idle
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign data_o       = data_q;
    assign data_valid_o = valid_q;
    assign parity_err_o = perr_out_q;
    assign frame_err_o  = ferr_q;
    assign uart_busy_o  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx; frames are driven bit by
//                bit, expected results queued at send time and compared when
//                data_valid_o pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int OVERSAMPLE = 16;
    localparam int STROBE_DIV = 4;
    localparam int BIT_CLKS   = OVERSAMPLE * STROBE_DIV;

    logic       clk;
    logic       reset_i;
    logic       sample_en_i;
    logic [2:0] Ctrl;
    logic       uart_rx_i;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       uart_busy_o;

    int checks  = 0;
    int errors  = 0;
    int n_valid = 0;
    logic [9:0] sb[$];

    uart_rx #(.OVERSAMPLE(OVERSAMPLE)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .sample_en_i  (sample_en_i),
        .Ctrl         (Ctrl),
        .uart_rx_i    (uart_rx_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .uart_busy_o  (uart_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe_gen();
        forever begin
            repeat (STROBE_DIV - 1) @(posedge clk);
            #1 sample_en_i = 1'b1;
            @(posedge clk);
            #1 sample_en_i = 1'b0;
        end
    endtask

    task automatic monitor();
        logic       prev;
        logic [9:0] exp;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                prev = 1'b0;
            end else begin
                if (data_valid_o) begin
                    n_valid++;
                    checks++;
                    if (prev) begin
                        errors++;
                        $display("FAIL valid_width: data_valid_o high %0d consecutive cycles, required 1", 2);
                    end
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_valid: got data=%h perr=%b ferr=%b, required no frame",
                                 data_o, parity_err_o, frame_err_o);
                    end else begin
                        exp = sb.pop_front();
                        if ({data_o, parity_err_o, frame_err_o} !== exp) begin
                            errors++;
                            $display("FAIL frame: got data=%h perr=%b ferr=%b, required data=%h perr=%b ferr=%b",
                                     data_o, parity_err_o, frame_err_o, exp[9:2], exp[1], exp[0]);
                        end
                    end
                end
                prev = data_valid_o;
            end
        end
    endtask

    function automatic logic exp_perr(input logic [7:0] d, input logic [2:0] c, input logic p);
        if (c == 3'b001) return (^d) ^ p;
        if (c == 3'b011) return ~((^d) ^ p);
        return 1'b0;
    endfunction

    // Drive one frame; Ctrl switches to ctrl_mid once the start bit is done
    task automatic send_frame(input logic [7:0] d, input logic [2:0] ctrl_start,
                              input logic [2:0] ctrl_mid, input logic p,
                              input logic stop, output logic busy_seen);
        logic has_par;
        has_par = (ctrl_start == 3'b001) || (ctrl_start == 3'b011);
        sb.push_back({d, exp_perr(d, ctrl_start, p), ~stop});
        Ctrl      = ctrl_start;
        uart_rx_i = 1'b0;
        hold(40);
        busy_seen = uart_busy_o;
        hold(BIT_CLKS - 40);
        Ctrl = ctrl_mid;
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = d[i];
            hold(BIT_CLKS);
        end
        if (has_par) begin
            uart_rx_i = p;
            hold(BIT_CLKS);
        end
        uart_rx_i = stop;
        hold(BIT_CLKS);
    endtask

    task automatic check_idle_after(input string name, input int valid_before, input int exp_frames);
        hold(BIT_CLKS);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: %0d frames not reported, required 0", name, sb.size());
            sb.delete();
        end
        checks++;
        if (n_valid - valid_before !== exp_frames) begin
            errors++;
            $display("FAIL %s_count: got %0d valid pulses, required %0d", name, n_valid - valid_before, exp_frames);
        end
        checks++;
        if (uart_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_end: got busy=%b, required 0", name, uart_busy_o);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        hold(5);
        checks++;
        if ({data_o, data_valid_o, parity_err_o, frame_err_o, uart_busy_o} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h v=%b pe=%b fe=%b busy=%b, required all 0",
                     data_o, data_valid_o, parity_err_o, frame_err_o, uart_busy_o);
        end
        reset_i = 1'b0;
        hold(10);
        checks++;
        if ({data_valid_o, uart_busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: got v=%b busy=%b, required 0 0", data_valid_o, uart_busy_o);
        end
    endtask

    task automatic test_no_parity();
        int   v0;
        logic busy_seen;
        v0 = n_valid;
        send_frame(8'hA5, 3'b000, 3'b000, 1'b0, 1'b1, busy_seen);
        checks++;
        if (busy_seen !== 1'b1) begin
            errors++;
            $display("FAIL nopar_busy: got busy=%b mid-frame, required 1", busy_seen);
        end
        check_idle_after("nopar", v0, 1);
    endtask

    task automatic test_even_parity();
        int   v0;
        logic busy_seen;
        v0 = n_valid;
        send_frame(8'h07, 3'b001, 3'b001, 1'b1, 1'b1, busy_seen);
        hold(BIT_CLKS);
        send_frame(8'h07, 3'b001, 3'b001, 1'b0, 1'b1, busy_seen);
        check_idle_after("even", v0, 2);
    endtask

    task automatic test_odd_parity();
        int   v0;
        logic busy_seen;
        v0 = n_valid;
        send_frame(8'h03, 3'b011, 3'b011, 1'b1, 1'b1, busy_seen);
        hold(BIT_CLKS);
        // Ctrl drops to 000 after the start bit; frame is still odd-checked
        send_frame(8'h03, 3'b011, 3'b000, 1'b0, 1'b1, busy_seen);
        check_idle_after("odd", v0, 2);
    endtask

    task automatic test_glitch();
        int   v0;
        logic busy_seen;
        v0 = n_valid;
        Ctrl      = 3'b000;
        uart_rx_i = 1'b0;
        hold(10);
        checks++;
        if (uart_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy: got busy=%b during glitch, required 1", uart_busy_o);
        end
        hold(4 * STROBE_DIV - 10);
        uart_rx_i = 1'b1;
        hold(BIT_CLKS);
        checks++;
        if (uart_busy_o !== 1'b0 || n_valid != v0) begin
            errors++;
            $display("FAIL glitch_reject: got busy=%b valids=%0d, required busy=0 valids=0",
                     uart_busy_o, n_valid - v0);
        end
        send_frame(8'h3C, 3'b000, 3'b000, 1'b0, 1'b1, busy_seen);
        check_idle_after("glitch", v0, 1);
    endtask

    task automatic test_break();
        int   v0;
        logic busy_seen;
        v0 = n_valid;
        send_frame(8'hFF, 3'b000, 3'b000, 1'b0, 1'b0, busy_seen);
        hold(2 * BIT_CLKS);
        checks++;
        if (n_valid - v0 !== 1 || uart_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL break_hold: got valids=%0d busy=%b while low, required valids=1 busy=1",
                     n_valid - v0, uart_busy_o);
        end
        uart_rx_i = 1'b1;
        hold(BIT_CLKS);
        send_frame(8'h55, 3'b000, 3'b000, 1'b0, 1'b1, busy_seen);
        check_idle_after("break", v0, 2);
    endtask

    task automatic test_reset_midframe();
        int   v0;
        logic busy_seen;
        logic [7:0] d;
        v0 = n_valid;
        d  = 8'hC6;
        Ctrl      = 3'b000;
        uart_rx_i = 1'b0;
        hold(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            uart_rx_i = d[i];
            hold(BIT_CLKS);
        end
        uart_rx_i = d[4];
        hold(BIT_CLKS / 2);
        reset_i   = 1'b1;
        uart_rx_i = 1'b1;
        hold(8);
        checks++;
        if ({data_o, data_valid_o, parity_err_o, frame_err_o, uart_busy_o} !== 12'h000) begin
            errors++;
            $display("FAIL midreset_outputs: got data=%h v=%b pe=%b fe=%b busy=%b, required all 0",
                     data_o, data_valid_o, parity_err_o, frame_err_o, uart_busy_o);
        end
        reset_i = 1'b0;
        hold(2 * BIT_CLKS);
        checks++;
        if (n_valid != v0 || uart_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_discard: got valids=%0d busy=%b, required 0 0", n_valid - v0, uart_busy_o);
        end
        send_frame(8'h81, 3'b000, 3'b000, 1'b0, 1'b1, busy_seen);
        check_idle_after("midreset", v0, 1);
    endtask

    initial begin
        reset_i     = 1'b1;
        sample_en_i = 1'b0;
        Ctrl        = 3'b000;
        uart_rx_i   = 1'b1;
        fork
            strobe_gen();
            monitor();
        join_none
        test_reset();
        test_no_parity();
        test_even_parity();
        test_odd_parity();
        test_glitch();
        test_break();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver paired with the team's UART transmitter: recovers 8-bit frames (start bit, 8 data bits LSB first, optional parity bit, one stop bit) from a serial line. Uses a 16x-baud sample-enable strobe from the shared baud generator. Uses the same 3-bit `Ctrl` parity encoding as the transmitter. Sits between the pad-side RX line and the host logic, delivering each byte with a one-cycle valid pulse and error flags.

## Interface
- `OVERSAMPLE`, 16: sample-enable strobes per bit period; must be an even value ≥ 4.
- `clk_i` input 1: system clock; all logic on its rising edge.
- `reset_i` input 1: asynchronous, active-high reset.
- `sample_en_i` input 1: one-`clk_i` strobe at OVERSAMPLE × baud rate.
- `Ctrl` input 3: parity mode.
  - 3'b001: parity on, even.
  - 3'b011: parity on, odd.
  - Any other value: parity off.
- `uart_rx_i` input 1: serial line; idles high; asynchronous to `clk_i`.
- `data_o` output 8: last received byte; held until the next frame completes.
- `data_valid_o` output 1: one-cycle pulse when `data_o` is updated.
- `parity_err_o` output 1: parity result of the frame being reported; valid with `data_valid_o`, held until the next completion.
- `frame_err_o` output 1: stop bit sampled 0; valid with `data_valid_o`, held until the next completion.
- `uart_busy_o` output 1: high from start-bit detection until the block returns to IDLE.

## Operation
- **Input synchronizer**
  - `uart_rx_i` passes through a 2-flop synchronizer (reset value 1) before any use.
  - The FSM sees only the synchronized value `rx_s`.
- **Counters**
  - `tick_cnt` is 4 bits wide and advances only on `sample_en_i`.
  - `bit_cnt` is 3 bits wide.
- **IDLE**
  - On `rx_s == 0`, clear `tick_cnt`, latch parity mode from `Ctrl`, and go to START.
  - Set `uart_busy_o` on this transition.
- **START**
  - After OVERSAMPLE/2 strobes (the mid-bit point), sample `rx_s`.
  - If `rx_s == 1`, the start was false: return to IDLE, drop `uart_busy_o`, report nothing.
  - If `rx_s == 0`, clear `tick_cnt` and `bit_cnt`, then go to DATA.
- **DATA**
  - Every OVERSAMPLE strobes, shift `rx_s` into the shift register at the MSB end. After 8 samples, bit 0 is the first received bit.
  - After the 8th sample, go to PARITY if parity is enabled, else go to STOP.
- **PARITY**
  - After OVERSAMPLE strobes, sample `rx_s` as the parity bit `p`.
  - Even mode: error = ^data ^ p ≠ 0.
  - Odd mode: error = ^data ^ p ≠ 1.
- **STOP**
  - After OVERSAMPLE strobes, sample `rx_s`.
  - Load `data_o` from the shift register.
  - Pulse `data_valid_o`.
  - Load `parity_err_o` (forced to 0 when parity is off).
  - Load `frame_err_o` = ~`rx_s`.
  - If `rx_s == 1`, go to IDLE. Otherwise go to BREAK.
- **BREAK**
  - Wait for `rx_s == 1`, then go to IDLE.
  - No further frames are reported while the line is held low.
- `uart_busy_o` falls on entry to IDLE.
- `Ctrl` changes mid-frame have no effect; the mode latched at start detection applies.
- **Reset** (any time, including mid-frame):
  - FSM goes to IDLE; counters clear; synchronizer flops are set to 1.
  - `data_o` = 8'h00; `data_valid_o`, `parity_err_o`, `frame_err_o`, `uart_busy_o` = 0.
  - A partial frame is discarded.

## Timing
- Start detection occurs 2–3 `clk_i` cycles after the falling edge of `uart_rx_i` (synchronizer latency).
- All bit samples are taken OVERSAMPLE strobes apart, starting at mid-start-bit. The nominal tolerance is about ±4% baud mismatch over a frame.
- `data_valid_o` asserts in the `clk_i` cycle after the `sample_en_i` strobe that samples the stop bit. `data_o` and both error flags change in that same cycle.
- A frame spans (10 + parity) × OVERSAMPLE strobes.
- Back-to-back frames are accepted. After the stop bit samples 1, IDLE is reached one cycle later, so a start edge arriving half a bit after the stop sample is detected.
- `sample_en_i` pulses wider than one cycle count as one strobe per cycle. The baud generator guarantees single-cycle strobes.

## Test plan
- **No parity (`Ctrl`=000), byte 0xA5, stop=1**
  - `data_o`=0xA5, one-cycle `data_valid_o`, both errors 0.
  - `uart_busy_o` high for the frame, then low.
- **Even parity (`Ctrl`=001), byte 0x07**
  - Parity bit 1: `parity_err_o`=0.
  - Repeat with parity bit 0: `data_o`=0x07, `parity_err_o`=1.
- **Odd parity (`Ctrl`=011), byte 0x03, parity bit 1**
  - `parity_err_o`=0.
  - Also switch `Ctrl` to 000 mid-frame: the frame is still checked as odd.
- **Glitch: `uart_rx_i` low for 4 strobes**
  - No `data_valid_o`; `uart_busy_o` pulses then returns to 0; the next valid frame 0x3C is received correctly.
- **Stop bit = 0 with line held low for 3 bit times, byte 0xFF**
  - `data_valid_o` with `frame_err_o`=1.
  - No second frame until the line returns high; a following frame 0x55 decodes with `frame_err_o`=0.
- **Reset asserted during DATA bit 4, then released, then frame 0x81 sent**
  - During reset all outputs are 0.
  - After reset, exactly one `data_valid_o` with `data_o`=0x81.
